// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: valid/ready handshake, two-entry skid buffer,
// flush-to-bubble, sticky destination tag and saturating stall counter.
module pipe_stage_reg #(
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEST_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              in_dest_en,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [DEST_W-1:0] out_dest,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_main_data;
    logic [DEST_W-1:0]   r_main_dest;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [DATA_W-1:0]   r_skid_data;
    logic [DEST_W-1:0]   r_skid_dest;
    logic [DEST_W-1:0]   r_last_dest;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic                w_accept;
    logic                w_drain;
    logic [DEST_W-1:0]   w_tag;
    logic                w_load_main;
    logic                w_load_skid;
    logic                w_skid_to_main;

    assign in_ready  = (r_state != StTwo);
    assign out_valid = (r_state != StEmpty);
    assign w_accept  = in_valid & in_ready;
    assign w_drain   = out_valid & out_ready;
    assign w_tag     = in_dest_en ? in_dest : r_last_dest;

    assign out_ctrl  = out_valid ? r_main_ctrl : '0;
    assign out_data  = r_main_data;
    assign out_dest  = r_main_dest;
    assign stall_cnt = r_stall_cnt;

    always_comb begin
        w_state_d      = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        if (flush) begin
            // A concurrent drain already completed downstream; everything else is dropped.
            w_state_d = StEmpty;
        end else begin
            case (r_state)
                StEmpty: begin
                    if (w_accept) begin
                        w_state_d   = StOne;
                        w_load_main = 1'b1;
                    end
                end
                StOne: begin
                    if (w_accept && !w_drain) begin
                        w_state_d   = StTwo;
                        w_load_skid = 1'b1;
                    end else if (w_drain && !w_accept) begin
                        w_state_d = StEmpty;
                    end else if (w_drain && w_accept) begin
                        w_load_main = 1'b1;
                    end
                end
                StTwo: begin
                    if (w_drain) begin
                        w_state_d      = StOne;
                        w_skid_to_main = 1'b1;
                    end
                end
                default: w_state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StEmpty;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_main_dest <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_dest <= '0;
            r_last_dest <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_load_main) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
                r_main_dest <= w_tag;
            end else if (w_skid_to_main) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
                r_main_dest <= r_skid_dest;
            end
            if (w_load_skid) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
                r_skid_dest <= w_tag;
            end
            // A flushed input is dropped, so its tag does not become sticky either.
            if (w_accept && in_dest_en && !flush) begin
                r_last_dest <= in_dest;
            end
            if (stall_clr) begin
                r_stall_cnt <= '0;
            end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: scoreboard queue of accepted entries,
// occupancy/stall-counter model, directed scenarios plus a random phase.
module tb_pipe_stage_reg;

    localparam int unsigned CtrlW = 16;
    localparam int unsigned DataW = 64;
    localparam int unsigned DestW = 4;
    localparam int unsigned CntW  = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [CtrlW-1:0] in_ctrl;
    logic [DataW-1:0] in_data;
    logic [DestW-1:0] in_dest;
    logic             in_dest_en;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [CtrlW-1:0] out_ctrl;
    logic [DataW-1:0] out_data;
    logic [DestW-1:0] out_dest;
    logic [CntW-1:0]  stall_cnt;
    logic             stall_clr;

    pipe_stage_reg #(
        .CTRL_W(CtrlW),
        .DATA_W(DataW),
        .DEST_W(DestW),
        .CNT_W (CntW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_dest_en(in_dest_en),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .out_dest  (out_dest),
        .stall_cnt (stall_cnt),
        .stall_clr (stall_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CtrlW-1:0] c;
        logic [DataW-1:0] d;
        logic [DestW-1:0] t;
    } ent_t;

    ent_t             q[$];
    logic [DestW-1:0] m_last;
    int unsigned      m_cnt;
    int               n_checks;
    int               n_errors;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Called just after a falling edge: drive inputs, check outputs, advance model by one edge.
    task automatic cyc(input logic v, input logic [CtrlW-1:0] c, input logic [DataW-1:0] d,
                       input logic [DestW-1:0] t, input logic en, input logic fl,
                       input logic ordy, input logic clr);
        ent_t e;
        logic m_acc;
        logic m_drain;
        in_valid   = v;
        in_ctrl    = c;
        in_data    = d;
        in_dest    = t;
        in_dest_en = en;
        flush      = fl;
        out_ready  = ordy;
        stall_clr  = clr;
        #1;
        check_eq("out_valid", 64'(out_valid), 64'(q.size() != 0));
        check_eq("in_ready", 64'(in_ready), 64'(q.size() != 2));
        check_eq("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        if (q.size() == 0) begin
            check_eq("bubble_ctrl", 64'(out_ctrl), 64'd0);
        end else if (ordy) begin
            check_eq("head_ctrl", 64'(out_ctrl), 64'(q[0].c));
            check_eq("head_data", out_data, q[0].d);
            check_eq("head_dest", 64'(out_dest), 64'(q[0].t));
        end
        m_acc   = v && (q.size() < 2);
        m_drain = (q.size() != 0) && ordy;
        if (clr) m_cnt = 0;
        else if ((q.size() != 0) && !ordy && (m_cnt < 15)) m_cnt++;
        if (fl) begin
            q.delete();
        end else begin
            if (m_drain) void'(q.pop_front());
            if (m_acc) begin
                e.c = c;
                e.d = d;
                e.t = en ? t : m_last;
                q.push_back(e);
                if (en) m_last = t;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, ordy, 1'b0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        m_last     = '0;
        m_cnt      = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_ctrl    = '0;
        in_data    = '0;
        in_dest    = '0;
        in_dest_en = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        stall_clr  = 1'b0;
        #3;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check_eq("rst_out_data", out_data, 64'd0);
        check_eq("rst_out_dest", 64'(out_dest), 64'd0);
        check_eq("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming at full rate.
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 16'(i), 64'(i), 4'(i), 1'b1, 1'b0, 1'b1, 1'b0);
        end
        idle(1'b1);
        idle(1'b1);

        // Backpressure: 10 enters, 11 goes to skid, 12 waits upstream for three stall cycles.
        cyc(1'b1, 16'h10, 64'd10, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 16'h11, 64'd11, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h12, 64'd12, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h12, 64'd12, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("bp_stall_cnt", 64'(stall_cnt), 64'd3);
        check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        cyc(1'b1, 16'h12, 64'd12, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 16'h12, 64'd12, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Sticky destination tag.
        cyc(1'b1, 16'h1, 64'h20, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 16'h2, 64'h21, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 16'h3, 64'h22, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("sticky_dest", 64'(out_dest), 64'd5);
        idle(1'b1);
        idle(1'b1);

        // Flush while full, with a concurrent input that must be dropped.
        cyc(1'b1, 16'hA, 64'h30, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'hB, 64'h31, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'hC, 64'h77, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("flush_out_valid", 64'(out_valid), 64'd0);
        check_eq("flush_out_ctrl", 64'(out_ctrl), 64'd0);
        check_eq("flush_in_ready", 64'(in_ready), 64'd1);
        idle(1'b1);
        idle(1'b1);

        // Counter saturation, then clear wins over a concurrent increment.
        cyc(1'b1, 16'hD, 64'h40, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) idle(1'b0);
        check_eq("cnt_saturated", 64'(stall_cnt), 64'd15);
        cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("cnt_cleared", 64'(stall_cnt), 64'd0);
        idle(1'b1);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 16'($urandom), {$urandom, $urandom},
                4'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));
        end
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Asynchronous reset while full, between clock edges.
        cyc(1'b1, 16'hE, 64'h50, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'hF, 64'h51, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("pre_rst_in_ready", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", 64'(out_valid), 64'd0);
        check_eq("arst_in_ready", 64'(in_ready), 64'd1);
        check_eq("arst_out_ctrl", 64'(out_ctrl), 64'd0);
        check_eq("arst_out_data", out_data, 64'd0);
        check_eq("arst_out_dest", 64'(out_dest), 64'd0);
        check_eq("arst_stall_cnt", 64'(stall_cnt), 64'd0);
        q.delete();
        m_last = '0;
        m_cnt  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 16'h5, 64'h60, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
